// File: rtl/uart_tx_framer.sv
// uart_tx_framer: AXI4-Stream byte in, UART 8N1/8N2 frame out on txd, LSB first.
// One bit period is eff_prescale*8 clk cycles, where a prescale of 0 counts as 1.
// Define UART_TX_PARITY_EN to add a parity bit between the data and stop bits.
// The parity_odd input selects odd parity; otherwise the parity is even.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic                  stop_bits,
  input  logic [15:0]           prescale
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                  parity_odd
`endif
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [18:0]             cnt_q, cnt_d;
  logic [18:0]             reload_q, reload_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic                    stop_idx_q, stop_idx_d;
  logic                    stop_bits_q, stop_bits_d;
  logic                    ready_en_q;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic        handshake;
  logic        bit_done;
  logic        last_stop;
  logic [15:0] eff_prescale;
  logic [18:0] load_val;

  assign handshake    = s_axis_tvalid && s_axis_tready;
  assign bit_done     = (cnt_q == 19'd0);
  assign last_stop    = (state_q == STOP) && bit_done && (stop_idx_q == stop_bits_q);
  assign eff_prescale = (prescale == 16'd0) ? 16'd1 : prescale;
  assign load_val     = {eff_prescale, 3'b000} - 19'd1;

  // State, timing and shift registers; reset aborts any frame and discards its byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reload_q    <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      stop_bits_q <= 1'b0;
      ready_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      stop_bits_q <= stop_bits_d;
      ready_en_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state logic: step through the frame when each bit period ends.
  // A handshake in the last stop cycle chains straight into the next start bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (handshake) state_d = START;
      START: if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done && (bit_idx_q == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP: begin
        if (last_stop) state_d = handshake ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the frame settings on acceptance.
  // Otherwise, count down each bit period, reload the counter and advance the shift register.
  always_comb begin
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    stop_bits_d = stop_bits_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    if (handshake) begin
      cnt_d       = load_val;
      reload_d    = load_val;
      shift_d     = s_axis_tdata;
      bit_idx_d   = '0;
      stop_idx_d  = 1'b0;
      stop_bits_d = stop_bits;
`ifdef UART_TX_PARITY_EN
      parity_d    = (^s_axis_tdata) ^ parity_odd;
`endif
    end else if (state_q != IDLE) begin
      if (bit_done) begin
        cnt_d = reload_q;
        if (state_q == DATA) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
        end
        if (state_q == STOP) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 19'd1;
      end
    end
  end

  // Outputs: drive txd per state; ready in IDLE after the first post-reset edge, and in the final stop cycle.
  always_comb begin
    busy          = (state_q != IDLE);
    s_axis_tready = ((state_q == IDLE) && ready_en_q) || last_stop;
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd = parity_q;
`endif
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer.
// Outputs are sampled on the falling edge, and index i in the capture arrays is the i-th cycle after a handshake edge.
module tb_uart_tx_framer;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        txd;
  logic        busy;
  logic        stop_bits;
  logic [15:0] prescale;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd;
`endif

  int compared = 0;
  int mismatched = 0;

  logic txd_cap  [0:511];
  logic busy_cap [0:511];
  logic rdy_cap  [0:511];

  uart_tx_framer #(.DATA_WIDTH(8)) dut (
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .txd          (txd),
    .busy         (busy),
    .stop_bits    (stop_bits),
    .prescale     (prescale)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a byte, wait (bounded) for tready, and return #1 after the handshake edge.
  task automatic applyStimulus(input logic [7:0] data, input logic sb, input logic [15:0] p,
                               input logic keep_valid);
    logic seen;
    seen = 1'b0;
    s_axis_tdata  = data;
    stop_bits     = sb;
    prescale      = p;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (s_axis_tready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("ready_wait", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) s_axis_tvalid = 1'b0;
  endtask

  task automatic captureCycles(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      txd_cap[i]  = txd;
      busy_cap[i] = busy;
      rdy_cap[i]  = s_axis_tready;
    end
  endtask

  // Compare captured cycles [first, first+n) with a bit-level frame model.
  // Any cycles past the end of the frame are expected to be idle.
  task automatic checkFrame(input string tag, input int first, input int n, input logic [7:0] data,
                            input logic sb, input int p, input logic par_en, input logic par_bit);
    int bp, len, b, bad_t, bad_b, bad_r;
    logic et, eb, er;
    bp = ((p == 0) ? 1 : p) * 8;
    len = (10 + int'(sb) + int'(par_en)) * bp;
    bad_t = 0; bad_b = 0; bad_r = 0;
    for (int i = 0; i < n; i++) begin
      if (i < len) begin
        b = i / bp;
        if (b == 0) et = 1'b0;
        else if (b <= 8) et = data[b-1];
        else if (par_en && b == 9) et = par_bit;
        else et = 1'b1;
        eb = 1'b1;
        er = (i == len - 1);
      end else begin
        et = 1'b1; eb = 1'b0; er = 1'b1;
      end
      if (txd_cap[first+i] !== et) bad_t++;
      if (busy_cap[first+i] !== eb) bad_b++;
      if (rdy_cap[first+i] !== er) bad_r++;
    end
    checkOutput({tag, "_txd_bad_cycles"}, bad_t, 0);
    checkOutput({tag, "_busy_bad_cycles"}, bad_b, 0);
    checkOutput({tag, "_ready_bad_cycles"}, bad_r, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    s_axis_tdata = 8'h00;
    s_axis_tvalid = 1'b0;
    stop_bits = 1'b0;
    prescale = 16'd1;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif

    // Reset state
    #1;
    checkOutput("reset_txd", {31'd0, txd}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_ready", {31'd0, s_axis_tready}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release_ready_low", {31'd0, s_axis_tready}, 32'd0);
    @(negedge clk);
    checkOutput("release_ready_high", {31'd0, s_axis_tready}, 32'd1);

    // Basic 8N1, prescale 1, 0x55
    applyStimulus(8'h55, 1'b0, 16'd1, 1'b0);
    captureCycles(0, 90);
    checkFrame("basic", 0, 90, 8'h55, 1'b0, 1, 1'b0, 1'b0);
    checkOutput("basic_start", {31'd0, txd_cap[0]}, 32'd0);
    checkOutput("basic_d0", {31'd0, txd_cap[12]}, 32'd1);
    checkOutput("basic_d1", {31'd0, txd_cap[20]}, 32'd0);
    checkOutput("basic_busy79", {31'd0, busy_cap[79]}, 32'd1);
    checkOutput("basic_busy80", {31'd0, busy_cap[80]}, 32'd0);
    checkOutput("basic_ready79", {31'd0, rdy_cap[79]}, 32'd1);
    checkOutput("basic_ready78", {31'd0, rdy_cap[78]}, 32'd0);

    // Back-to-back with tvalid held high, prescale 2: 0xA5 then 0x3C
    applyStimulus(8'hA5, 1'b0, 16'd2, 1'b1);
    s_axis_tdata = 8'h3C;
    captureCycles(0, 161);
    s_axis_tvalid = 1'b0;
    captureCycles(161, 169);
    checkFrame("b2b_first", 0, 160, 8'hA5, 1'b0, 2, 1'b0, 1'b0);
    checkFrame("b2b_second", 160, 170, 8'h3C, 1'b0, 2, 1'b0, 1'b0);
    checkOutput("b2b_stop_end", {31'd0, txd_cap[159]}, 32'd1);
    checkOutput("b2b_start2", {31'd0, txd_cap[160]}, 32'd0);

    // Two stop bits, prescale 0 treated as 1, 0xFF
    applyStimulus(8'hFF, 1'b1, 16'd0, 1'b0);
    captureCycles(0, 96);
    checkFrame("sb2_p0", 0, 96, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("sb2_busy87", {31'd0, busy_cap[87]}, 32'd1);
    checkOutput("sb2_busy88", {31'd0, busy_cap[88]}, 32'd0);

    // Reset during data bit 3 of 0x00
    applyStimulus(8'h00, 1'b0, 16'd1, 1'b0);
    captureCycles(0, 35);
    checkOutput("rst_pre_txd", {31'd0, txd_cap[34]}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_txd", {31'd0, txd}, 32'd1);
    checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_async_ready", {31'd0, s_axis_tready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_ready_low", {31'd0, s_axis_tready}, 32'd0);
    @(negedge clk);
    checkOutput("rst_release_ready_high", {31'd0, s_axis_tready}, 32'd1);
    captureCycles(0, 100);
    bad = 0;
    for (int i = 0; i < 100; i++) if (txd_cap[i] !== 1'b1 || busy_cap[i] !== 1'b0) bad++;
    checkOutput("rst_no_residual_frame", bad, 0);

    // Config change mid-frame: prescale 4 -> 1 and stop_bits 0 -> 1 during DATA
    applyStimulus(8'h96, 1'b0, 16'd4, 1'b0);
    captureCycles(0, 100);
    prescale = 16'd1;
    stop_bits = 1'b1;
    captureCycles(100, 230);
    checkFrame("cfg_old", 0, 330, 8'h96, 1'b0, 4, 1'b0, 1'b0);
    applyStimulus(8'h4B, 1'b0, 16'd1, 1'b0);
    captureCycles(0, 90);
    checkFrame("cfg_new", 0, 90, 8'h4B, 1'b0, 1, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 even then odd
    parity_odd = 1'b0;
    applyStimulus(8'h07, 1'b0, 16'd1, 1'b0);
    captureCycles(0, 96);
    checkFrame("par_even", 0, 96, 8'h07, 1'b0, 1, 1'b1, 1'b1);
    checkOutput("par_even_bit", {31'd0, txd_cap[76]}, 32'd1);
    parity_odd = 1'b1;
    applyStimulus(8'h07, 1'b0, 16'd1, 1'b0);
    captureCycles(0, 96);
    checkFrame("par_odd", 0, 96, 8'h07, 1'b0, 1, 1'b1, 1'b0);
    checkOutput("par_odd_bit", {31'd0, txd_cap[76]}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
